// File: rtl/step_pulse_gen.sv
// Debounced push-button to single-cycle step pulse with direction and enable switches.
// Optional auto-repeat while held is built when STEP_AUTOREPEAT_EN is defined.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [1:0] sw,
  output logic       step,
  output logic       dir,
  output logic       pressed
);

`ifdef STEP_AUTOREPEAT_EN
  localparam int HR_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > HR_MAX) ? DEBOUNCE_CYCLES : HR_MAX;
`else
  localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef STEP_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             pressed_q, pressed_d;
  logic             btn_m_q, btn_m_d, btn_s_q, btn_s_d;
  logic [1:0]       sw_m_q, sw_m_d, sw_s_q, sw_s_d;
  logic             fire;
`ifdef STEP_AUTOREPEAT_EN
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             rpt_first_q, rpt_first_d;
`endif

  always_comb begin
    btn_m_d   = btn;
    btn_s_d   = btn_m_q;
    sw_m_d    = sw;
    sw_s_d    = sw_m_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    pressed_d = pressed_q;
    fire      = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (cnt_q >= DB_LAST) begin
          state_d   = HELD;
          pressed_d = 1'b1;
          fire      = 1'b1;
          cnt_d     = '0;
`ifdef STEP_AUTOREPEAT_EN
          rpt_d       = '0;
          rpt_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef STEP_AUTOREPEAT_EN
        // Repeat timer only advances in HELD, so release glitches pause it.
        else if (rpt_q >= (rpt_first_q ? HOLD_LAST : REP_LAST)) begin
          fire        = 1'b1;
          rpt_d       = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (btn_s_q) begin
          state_d = HELD;
        end else if (cnt_q >= DB_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Enable gates only the pulse; direction is captured with each emitted pulse.
    if (fire && sw_s_q[1] && !step_q) begin
      step_d = 1'b1;
      dir_d  = sw_s_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      pressed_q <= 1'b0;
      btn_m_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      sw_m_q    <= 2'b00;
      sw_s_q    <= 2'b00;
`ifdef STEP_AUTOREPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pressed_q <= pressed_d;
      btn_m_q   <= btn_m_d;
      btn_s_q   <= btn_s_d;
      sw_m_q    <= sw_m_d;
      sw_s_q    <= sw_s_d;
`ifdef STEP_AUTOREPEAT_EN
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=4.
// Expectations for held presses depend on whether STEP_AUTOREPEAT_EN is defined.
module tb_step_pulse_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [1:0] sw;
  logic       step, dir, pressed;

  int n_chk  = 0;
  int n_fail = 0;
  int consec = 0;
  logic prev_step = 1'b0;

  step_pulse_gen #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
    .step(step), .dir(dir), .pressed(pressed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step && prev_step) consec++;
    prev_step = step;
  end

  typedef struct {
    int         hi;
    logic [1:0] sw;
    int         exp_steps;
    logic       exp_seen;
    logic       exp_dir;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int steps, first_step, step_dir, fall, drops, seen;
    int exp_edges[$];
    int got_edges[$];

    tbl[0] = '{1,  2'b11, 0, 1'b0, 1'b1};
    tbl[1] = '{2,  2'b11, 0, 1'b0, 1'b1};
    tbl[2] = '{3,  2'b11, 0, 1'b0, 1'b1};
    tbl[3] = '{4,  2'b11, 0, 1'b0, 1'b1};
    tbl[4] = '{5,  2'b11, 1, 1'b1, 1'b1};
    tbl[5] = '{12, 2'b01, 0, 1'b1, 1'b1};
    tbl[6] = '{12, 2'b10, 1, 1'b1, 1'b0};
    tbl[7] = '{12, 2'b00, 0, 1'b1, 1'b0};
    tbl[8] = '{12, 2'b11, 1, 1'b1, 1'b1};
    tbl[9] = '{5,  2'b01, 0, 1'b1, 1'b1};

    rst_n = 1'b0; btn = 1'b0; sw = 2'b00;
    tick(); tick();
    check("reset_step", step, 0);
    check("reset_dir", dir, 0);
    check("reset_pressed", pressed, 0);
    rst_n = 1'b1;
    idle(3);

    // Single press: latency, dir, release debounce
    sw = 2'b11; btn = 1'b1;
    steps = 0; first_step = 0; step_dir = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (step) begin
        steps++;
        if (first_step == 0) begin first_step = k; step_dir = dir; end
      end
    end
    btn = 1'b0; fall = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (step) steps++;
      if (!pressed && fall == 0) fall = k;
    end
    check("latency_edge", first_step, 7);
    check("latency_dir", step_dir, 1);
    check("release_fall_edge", fall, 7);
`ifdef STEP_AUTOREPEAT_EN
    check("press20_steps", steps, 3);
`else
    check("press20_steps", steps, 1);
`endif

    // Two-cycle low glitch while held
    steps = 0; drops = 0;
    for (int k = 1; k <= 35; k++) begin
      btn = (k <= 12) || (k >= 15 && k <= 20);
      tick();
      if (step) steps++;
      if (k >= 7 && k <= 24 && !pressed) drops++;
    end
    check("glitch_pressed_drops", drops, 0);
`ifdef STEP_AUTOREPEAT_EN
    check("glitch_steps", steps, 3);
`else
    check("glitch_steps", steps, 1);
`endif
    idle(5);

    // Table: pulse length and switch settings
    for (int t = 0; t < 10; t++) begin
      sw = tbl[t].sw; btn = 1'b1;
      steps = 0; seen = 0; step_dir = -1;
      for (int k = 1; k <= tbl[t].hi + 15; k++) begin
        if (k > tbl[t].hi) btn = 1'b0;
        tick();
        if (step) begin steps++; step_dir = dir; end
        if (pressed) seen = 1;
      end
      check($sformatf("tbl%0d_steps", t), steps, tbl[t].exp_steps);
      check($sformatf("tbl%0d_pressed_seen", t), seen, int'(tbl[t].exp_seen));
      check($sformatf("tbl%0d_dir", t), dir, int'(tbl[t].exp_dir));
      check($sformatf("tbl%0d_pressed_end", t), pressed, 0);
    end

    // Reset in PRESS_WAIT at count 2, btn kept high
    sw = 2'b11; btn = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_step", step, 0);
    check("midrst_dir", dir, 0);
    check("midrst_pressed", pressed, 0);
    tick();
    rst_n = 1'b1;
    steps = 0; first_step = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (step) begin
        steps++;
        if (first_step == 0) first_step = k;
      end
    end
    check("midrst_step_edge", first_step, 7);
    check("midrst_steps", steps, 1);
    check("midrst_pressed_after", pressed, 1);
    idle(15);

    // Long hold: auto-repeat pattern
`ifdef STEP_AUTOREPEAT_EN
    exp_edges = '{7, 15, 19, 23, 27, 31, 35};
`else
    exp_edges = '{7};
`endif
    sw = 2'b10; btn = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      if (k > 35) btn = 1'b0;
      tick();
      if (step) got_edges.push_back(k);
    end
    check("hold_step_count", got_edges.size(), exp_edges.size());
    for (int i = 0; i < exp_edges.size() && i < got_edges.size(); i++)
      check($sformatf("hold_step%0d_edge", i), got_edges[i], exp_edges[i]);
    check("hold_dir", dir, 0);
    check("no_back_to_back_steps", consec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
